// File: rtl/rom_stream_reader.sv
// Burst reader for the synchronous cs/rd ROM: reads count words from base_addr and streams them valid/ready.
// First word 2 cycles after busy rises, then 1 word/cycle; reads stall while FIFO + in-flight read would exceed 2.
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining;
  logic              inflight;
  logic              inflight_last;
  entry_t            fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        occ;
  entry_t            head;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_read;
  logic [2:0]        level;

  assign head      = fifo_mem[rd_ptr];
  assign accept    = (state == IDLE) && start;
  assign pop       = (occ != 2'd0) && out_ready;
  assign push      = inflight;
  assign last_read = (remaining == CNT_W'(1));

  // Slots already committed after this cycle's pop; a new read needs one free.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == READ) && (remaining != '0) && (level < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (issue && last_read) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    mem_cs    = (state == READ) || (state == DRAIN);
    mem_rd    = issue;
    mem_addr  = addr_q;
    out_valid = (occ != 2'd0);
    out_data  = head.data;
    out_last  = (occ != 2'd0) && head.last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= 2'd0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
    end else begin
      if (accept && (count != '0)) begin
        addr_q    <= base_addr;
        remaining <= count;
      end else if (issue) begin
        addr_q    <= addr_q + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end

      // ROM data appears the cycle after the read; capture it then.
      inflight      <= issue;
      inflight_last <= issue && last_read;

      if (push) begin
        fifo_mem[wr_ptr] <= {inflight_last, mem_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader against a 16x8 squares ROM model.
module tb_rom_stream_reader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 5;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          mem_cs;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] rom [16];
  exp_t          exp_q[$];
  int            addr_log[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cnt_busy, cnt_done, cnt_cs, cnt_rd, hs_cnt;
  int first_busy, first_vld, first_hs, last_hs, first_done, start_cyc;
  int m_occ = 0;
  int m_inf = 0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  int            ready_mode = 0;
  logic [3:0]    ready_pat = 4'b1001;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  // Registered ROM: holds its output unless a read is strobed.
  initial mem_data = '0;
  always @(posedge clk) begin
    if (mem_cs && mem_rd) mem_data <= rom[mem_addr];
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop, read-issue rule, hold stability, activity counters.
  always @(negedge clk) begin
    int p;
    cyc++;
    if (rst) begin
      m_occ = 0;
      m_inf = 0;
      hold_pending = 1'b0;
    end else begin
      p = (out_valid && out_ready) ? 1 : 0;
      if (busy) cnt_busy++;
      if (busy && first_busy < 0) first_busy = cyc;
      if (done) begin
        cnt_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (mem_cs) cnt_cs++;
      if (start && !busy) start_cyc = cyc;
      if (out_valid && first_vld < 0) first_vld = cyc;
      check("valid_vs_model_occupancy", int'(out_valid), (m_occ != 0) ? 1 : 0);
      if (mem_rd) begin
        cnt_rd++;
        addr_log.push_back(int'(mem_addr));
        check("rd_with_fifo_full", (m_occ + m_inf - p < 2) ? 1 : 0, 1);
      end
      if (hold_pending) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(held_data));
        check("hold_last", int'(out_last), int'(held_last));
      end
      hold_pending = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (p == 1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", int'(out_data), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e.data));
          check("out_last", int'(out_last), int'(e.last));
        end
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      m_occ = m_occ + m_inf - p;
      m_inf = mem_rd ? 1 : 0;
    end
  end

  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ready_pat[3-ph];
        ph = (ph + 1) % 4;
      end
    end
  end

  task automatic clear_stats();
    cnt_busy = 0; cnt_done = 0; cnt_cs = 0; cnt_rd = 0; hs_cnt = 0;
    first_busy = -1; first_vld = -1; first_hs = -1; last_hs = -1;
    first_done = -1; start_cyc = -1;
    addr_log.delete();
  endtask

  task automatic do_start(input int b, input int c, input bit accepted);
    exp_t e;
    base_addr = AW'(b);
    count     = CW'(c);
    start     = 1'b1;
    if (accepted) begin
      for (int i = 0; i < c; i++) begin
        e.data = rom[(b + i) % 16];
        e.last = (i == c - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (cnt_done > 0) break;
      @(posedge clk);
      #1;
    end
    check({name, "_done_seen"}, (cnt_done > 0) ? 1 : 0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = DW'((i * i) % 256);
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_cs", int'(mem_cs), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: base 0, count 5, streaming
    clear_stats();
    do_start(0, 5, 1);
    wait_done("t1", 50);
    check("t1_done_count", cnt_done, 1);
    check("t1_rd_count", cnt_rd, 5);
    check("t1_handshakes", hs_cnt, 5);
    check("t1_back_to_back", last_hs - first_hs, 4);
    check("t1_busy_after_start", first_busy - start_cyc, 1);
    check("t1_first_word_latency", first_vld - first_busy, 2);
    check("t1_queue_left", exp_q.size(), 0);

    // 2: address wrap 14,15,0,1
    clear_stats();
    do_start(14, 4, 1);
    wait_done("t2", 50);
    check("t2_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t2_addr0", addr_log[0], 14);
      check("t2_addr1", addr_log[1], 15);
      check("t2_addr2", addr_log[2], 0);
      check("t2_addr3", addr_log[3], 1);
    end
    check("t2_done_count", cnt_done, 1);
    check("t2_queue_left", exp_q.size(), 0);

    // 3: full ROM with backpressure 1,0,0,1
    clear_stats();
    ready_mode = 1;
    do_start(0, 16, 1);
    wait_done("t3", 400);
    ready_mode = 0;
    check("t3_handshakes", hs_cnt, 16);
    check("t3_rd_count", cnt_rd, 16);
    check("t3_done_count", cnt_done, 1);
    check("t3_queue_left", exp_q.size(), 0);

    // 4: zero-length burst
    clear_stats();
    do_start(5, 0, 1);
    wait_done("t4", 20);
    check("t4_done_next_cycle", first_done - start_cyc, 1);
    check("t4_done_count", cnt_done, 1);
    check("t4_busy_cycles", cnt_busy, 1);
    check("t4_cs_cycles", cnt_cs, 0);
    check("t4_rd_count", cnt_rd, 0);

    // 5: reset during word 3 of an 8-word burst
    clear_stats();
    do_start(0, 8, 1);
    for (int k = 0; k < 50; k++) begin
      if (hs_cnt >= 2) break;
      @(posedge clk);
      #1;
    end
    check("t5_two_words_before_reset", hs_cnt, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("t5_busy", int'(busy), 0);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_mem_cs", int'(mem_cs), 0);
    check("t5_done", int'(done), 0);
    clear_stats();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("t5_no_done_after_abort", cnt_done, 0);
    check("t5_no_cs_after_abort", cnt_cs, 0);
    clear_stats();
    do_start(2, 2, 1);
    wait_done("t5b", 50);
    check("t5b_handshakes", hs_cnt, 2);
    check("t5b_queue_left", exp_q.size(), 0);

    // 6: second start mid-burst is ignored
    clear_stats();
    do_start(3, 6, 1);
    @(posedge clk);
    #1;
    do_start(9, 3, 0);
    wait_done("t6", 60);
    check("t6_handshakes", hs_cnt, 6);
    check("t6_rd_count", cnt_rd, 6);
    check("t6_done_count", cnt_done, 1);
    check("t6_addr_count", addr_log.size(), 6);
    if (addr_log.size() == 6) begin
      check("t6_addr_first", addr_log[0], 3);
      check("t6_addr_last", addr_log[5], 8);
    end
    check("t6_queue_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
